// File: rtl/int_entry_seq.sv
// Interrupt/exception entry and RETI sequencer: saves {ie, pc} on a small
// hardware stack, stalls the core and redirects the PC to the vector.
module int_entry_seq #(
   parameter int unsigned ADDR_WIDTH = 24,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       exp_clr,
   input  logic                       int_req,
   input  logic [ADDR_WIDTH-1:0]      ivec_addr,
   input  logic                       exp_req,
   input  logic [ADDR_WIDTH-1:0]      exp_vec,
   input  logic                       instr_done,
   input  logic [ADDR_WIDTH-1:0]      pc_next,
   input  logic                       reti,
   input  logic                       sei,
   output logic                       cpu_hold,
   output logic                       pc_load,
   output logic [ADDR_WIDTH-1:0]      pc_target,
   output logic                       int_ack,
   output logic                       exp_ack,
   output logic                       in_service,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       stack_ovf
);
   localparam int unsigned   DW   = $clog2(DEPTH + 1);
   localparam int unsigned   IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DW-1:0] DMAX = DW'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_VECTOR, ST_RETURN} state_t;
   state_t state, state_nxt;

   logic                  ie;
   logic                  exp_q;
   logic [ADDR_WIDTH-1:0] vec_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] stk_pc [DEPTH];
   logic                  stk_ie [DEPTH];
   logic                  acc_exp;
   logic                  acc_int;
   logic                  full;
   logic [IW-1:0]         top_idx;
   logic [IW-1:0]         push_idx;

   // A push at full depth (exceptions only) overwrites the top entry.
   assign full       = (depth == DMAX);
   assign top_idx    = IW'(depth - DW'(1));
   assign push_idx   = full ? IW'(DEPTH - 1) : IW'(depth);
   assign in_service = (depth != '0);

   always_ff @(posedge clk or posedge exp_clr) begin
      if (exp_clr) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      acc_exp   = 1'b0;
      acc_int   = 1'b0;
      cpu_hold  = 1'b0;
      pc_load   = 1'b0;
      pc_target = '0;
      int_ack   = 1'b0;
      exp_ack   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (instr_done) begin
               if (exp_req) begin
                  acc_exp   = 1'b1;
                  state_nxt = ST_SAVE;
               end else if (int_req && ie && !full) begin
                  acc_int   = 1'b1;
                  state_nxt = ST_SAVE;
               end else if (reti && depth != '0) begin
                  state_nxt = ST_RETURN;
               end
            end
         end
         ST_SAVE: begin
            cpu_hold  = 1'b1;
            state_nxt = ST_VECTOR;
         end
         ST_VECTOR: begin
            cpu_hold  = 1'b1;
            pc_load   = 1'b1;
            pc_target = vec_q;
            int_ack   = !exp_q;
            exp_ack   = exp_q;
            state_nxt = ST_IDLE;
         end
         ST_RETURN: begin
            cpu_hold  = 1'b1;
            pc_load   = 1'b1;
            pc_target = stk_pc[top_idx];
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge exp_clr) begin
      if (exp_clr) begin
         ie        <= 1'b1;
         depth     <= '0;
         stack_ovf <= 1'b0;
         exp_q     <= 1'b0;
         vec_q     <= '0;
         pc_q      <= '0;
      end else begin
         if (sei) ie <= 1'b1;
         if (acc_exp || acc_int) begin
            vec_q <= acc_exp ? exp_vec : ivec_addr;
            exp_q <= acc_exp;
            pc_q  <= pc_next;
         end
         // Later assignments override sei: the SAVE clear wins, RETURN merges.
         case (state)
            ST_SAVE: begin
               ie <= 1'b0;
               if (full) stack_ovf <= 1'b1;
               else      depth     <= depth + DW'(1);
            end
            ST_RETURN: begin
               ie    <= stk_ie[top_idx] | sei;
               depth <= depth - DW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_SAVE) begin
         stk_pc[push_idx] <= pc_q;
         stk_ie[push_idx] <= ie;
      end
   end

endmodule

// File: tb/tb_int_entry_seq.sv
// Bench for int_entry_seq: directed test-plan sequences plus randomized traffic
// checked every cycle against a queue-based model of the entry/return sequencer.
module tb_int_entry_seq;
   localparam int unsigned AW    = 24;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          exp_clr = 1'b0;
   logic          int_req = 1'b0;
   logic [AW-1:0] ivec_addr = '0;
   logic          exp_req = 1'b0;
   logic [AW-1:0] exp_vec = '0;
   logic          instr_done = 1'b0;
   logic [AW-1:0] pc_next = '0;
   logic          reti = 1'b0;
   logic          sei = 1'b0;
   logic          cpu_hold, pc_load, int_ack, exp_ack, in_service, stack_ovf;
   logic [AW-1:0] pc_target;
   logic [DW-1:0] depth;

   int_entry_seq #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .exp_clr(exp_clr), .int_req(int_req), .ivec_addr(ivec_addr),
      .exp_req(exp_req), .exp_vec(exp_vec), .instr_done(instr_done),
      .pc_next(pc_next), .reti(reti), .sei(sei), .cpu_hold(cpu_hold),
      .pc_load(pc_load), .pc_target(pc_target), .int_ack(int_ack),
      .exp_ack(exp_ack), .in_service(in_service), .depth(depth),
      .stack_ovf(stack_ovf)
   );

   always #5 clk = ~clk;

   // Model: a stack of saved contexts and a schedule of upcoming busy cycles.
   typedef struct { logic ie; logic [AW-1:0] pc; } ent_t;
   typedef struct {
      logic hold; logic load; logic [AW-1:0] tgt; logic iack; logic eack; int act;
   } slot_t;

   ent_t          stk[$];
   slot_t         sched[$];
   logic          m_ie;
   logic          m_ovf;
   logic [AW-1:0] lat_pc;
   int            total = 0;
   int            bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      stk.delete();
      sched.delete();
      m_ie  = 1'b1;
      m_ovf = 1'b0;
   endtask

   task automatic model_step();
      slot_t s1, s2;
      ent_t  e;
      if (exp_clr) begin
         m_reset();
         return;
      end
      if (sched.size() != 0) begin
         s1 = sched.pop_front();
         if (s1.act == 1) begin
            e.ie = m_ie;
            e.pc = lat_pc;
            if (stk.size() == DEPTH) begin
               m_ovf = 1'b1;
               stk[DEPTH-1] = e;
            end else begin
               stk.push_back(e);
            end
            m_ie = 1'b0;
         end else if (s1.act == 2) begin
            e = stk.pop_back();
            m_ie = e.ie | sei;
         end else if (sei) begin
            m_ie = 1'b1;
         end
      end else begin
         if (instr_done && (exp_req || (int_req && m_ie && stk.size() < DEPTH))) begin
            lat_pc  = pc_next;
            s1.hold = 1'b1; s1.load = 1'b0; s1.tgt = '0; s1.iack = 1'b0; s1.eack = 1'b0; s1.act = 1;
            s2.hold = 1'b1; s2.load = 1'b1; s2.tgt = exp_req ? exp_vec : ivec_addr;
            s2.iack = !exp_req; s2.eack = exp_req; s2.act = 0;
            sched.push_back(s1);
            sched.push_back(s2);
         end else if (instr_done && reti && stk.size() > 0) begin
            s1.hold = 1'b1; s1.load = 1'b1; s1.tgt = stk[stk.size()-1].pc;
            s1.iack = 1'b0; s1.eack = 1'b0; s1.act = 2;
            sched.push_back(s1);
         end
         if (sei) m_ie = 1'b1;
      end
   endtask

   task automatic check_all();
      slot_t s;
      s.hold = 1'b0; s.load = 1'b0; s.tgt = '0; s.iack = 1'b0; s.eack = 1'b0; s.act = 0;
      if (sched.size() != 0) s = sched[0];
      chk("cpu_hold",   32'(cpu_hold),   32'(s.hold));
      chk("pc_load",    32'(pc_load),    32'(s.load));
      chk("pc_target",  32'(pc_target),  32'(s.tgt));
      chk("int_ack",    32'(int_ack),    32'(s.iack));
      chk("exp_ack",    32'(exp_ack),    32'(s.eack));
      chk("depth",      32'(depth),      32'(stk.size()));
      chk("in_service", 32'(in_service), 32'(stk.size() != 0));
      chk("stack_ovf",  32'(stack_ovf),  32'(m_ovf));
   endtask

   task automatic cyc(input logic id, input logic ir, input logic [AW-1:0] iv,
                      input logic er, input logic [AW-1:0] ev, input logic [AW-1:0] pn,
                      input logic rt, input logic se);
      instr_done = id; int_req = ir; ivec_addr = iv; exp_req = er;
      exp_vec = ev; pc_next = pn; reti = rt; sei = se;
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle1();
      cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      exp_clr = 1'b1;
      m_reset();
      idle1();
      idle1();
      exp_clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      m_reset();
      do_reset();
      chk("rst_depth", 32'(depth), 32'd0);
      chk("rst_ovf",   32'(stack_ovf), 32'd0);

      // Interrupt entry, vector change after acceptance is ignored
      cyc(1'b1, 1'b1, 24'h001040, 1'b0, '0, 24'h000200, 1'b0, 1'b0);
      chk("t1_save_hold", 32'(cpu_hold), 32'd1);
      chk("t1_save_load", 32'(pc_load), 32'd0);
      cyc(1'b0, 1'b1, 24'h00ffff, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("t1_vec_load", 32'(pc_load), 32'd1);
      chk("t1_vec_tgt",  32'(pc_target), 32'h001040);
      chk("t1_vec_iack", 32'(int_ack), 32'd1);
      chk("t1_vec_dep",  32'(depth), 32'd1);
      cyc(1'b0, 1'b1, 24'h00ffff, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("t1_idle_hold", 32'(cpu_hold), 32'd0);

      // RETI back to 0x200
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 24'h000250, 1'b1, 1'b0);
      chk("t2_ret_load", 32'(pc_load), 32'd1);
      chk("t2_ret_tgt",  32'(pc_target), 32'h000200);
      idle1();
      chk("t2_dep0", 32'(depth), 32'd0);
      chk("t2_insvc", 32'(in_service), 32'd0);

      // Nesting gated by ie, opened by sei, unwound LIFO
      cyc(1'b1, 1'b1, 24'h001040, 1'b0, '0, 24'h000300, 1'b0, 1'b0);
      idle1();
      idle1();
      cyc(1'b1, 1'b1, 24'h002000, 1'b0, '0, 24'h000310, 1'b0, 1'b0);
      chk("t3_blocked", 32'(cpu_hold), 32'd0);
      cyc(1'b0, 1'b1, 24'h002000, 1'b0, '0, '0, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 24'h002000, 1'b0, '0, 24'h000400, 1'b0, 1'b0);
      chk("t3_nest_hold", 32'(cpu_hold), 32'd1);
      idle1();
      chk("t3_nest_tgt", 32'(pc_target), 32'h002000);
      chk("t3_nest_dep", 32'(depth), 32'd2);
      idle1();
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 24'h000500, 1'b1, 1'b0);
      chk("t3_ret1_tgt", 32'(pc_target), 32'h000400);
      idle1();
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 24'h000510, 1'b1, 1'b0);
      chk("t3_ret2_tgt", 32'(pc_target), 32'h000300);
      idle1();
      chk("t3_dep0", 32'(depth), 32'd0);

      // Exception beats interrupt; interrupt stays pending until sei
      do_reset();
      cyc(1'b1, 1'b1, 24'h001040, 1'b1, 24'h000010, 24'h000600, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 24'h001040, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("t4_eack", 32'(exp_ack), 32'd1);
      chk("t4_iack", 32'(int_ack), 32'd0);
      chk("t4_tgt",  32'(pc_target), 32'h000010);
      cyc(1'b0, 1'b1, 24'h001040, 1'b0, '0, '0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 24'h001040, 1'b0, '0, 24'h000700, 1'b0, 1'b0);
      chk("t4_pend_hold", 32'(cpu_hold), 32'd0);
      cyc(1'b0, 1'b1, 24'h001040, 1'b0, '0, '0, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 24'h001040, 1'b0, '0, 24'h000710, 1'b0, 1'b0);
      idle1();
      chk("t4_nest_iack", 32'(int_ack), 32'd1);
      idle1();
      chk("t4_nest_dep", 32'(depth), 32'd2);

      // Fill the stack with exceptions, then overflow
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, 1'b0, '0, 1'b1, AW'(32'h20 + i), AW'(32'h800 + 16 * i), 1'b0, 1'b0);
         idle1();
         idle1();
      end
      chk("t5_full_dep", 32'(depth), 32'(DEPTH));
      cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 24'h001040, 1'b0, '0, 24'h000880, 1'b0, 1'b0);
      chk("t5_full_noint", 32'(cpu_hold), 32'd0);
      cyc(1'b1, 1'b1, 24'h001040, 1'b1, 24'h000080, 24'h000900, 1'b0, 1'b0);
      idle1();
      chk("t5_ovf_tgt",  32'(pc_target), 32'h000080);
      chk("t5_ovf_eack", 32'(exp_ack), 32'd1);
      chk("t5_ovf_flag", 32'(stack_ovf), 32'd1);
      idle1();
      chk("t5_ovf_sticky", 32'(stack_ovf), 32'd1);
      chk("t5_ovf_dep",    32'(depth), 32'(DEPTH));

      // Asynchronous reset in the middle of VECTOR
      cyc(1'b1, 1'b0, '0, 1'b1, 24'h0000c0, 24'h000a00, 1'b0, 1'b0);
      idle1();
      chk("t6_vec_load", 32'(pc_load), 32'd1);
      exp_clr = 1'b1;
      m_reset();
      #1;
      chk("t6_clr_load", 32'(pc_load), 32'd0);
      chk("t6_clr_eack", 32'(exp_ack), 32'd0);
      chk("t6_clr_hold", 32'(cpu_hold), 32'd0);
      chk("t6_clr_dep",  32'(depth), 32'd0);
      chk("t6_clr_ovf",  32'(stack_ovf), 32'd0);
      idle1();
      exp_clr = 1'b0;
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 24'h000100, 1'b1, 1'b0);
      chk("t6_reti_dep0", 32'(pc_load), 32'd0);
      cyc(1'b1, 1'b1, 24'h001111, 1'b0, '0, 24'h000b00, 1'b0, 1'b0);
      chk("t6_ie_set", 32'(cpu_hold), 32'd1);
      idle1();
      idle1();

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 35, AW'($urandom),
                $urandom_range(0, 99) < 8, AW'($urandom), AW'($urandom),
                $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 10);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
